mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port 32-bit RAM between the instruction-fetch port and the data (load/store) port of the openmips core inside openmips_min_sopc.
- Grants one port at a time, sequences the fixed-latency RAM access, and returns data with a one-cycle ack.
- Raises a stall request to ctrl while any port is waiting.
- Supports a fetch flush that discards an in-flight fetch result after a branch or exception.

Parameters:
- RAM_LATENCY, 1, cycles from first cycle of ram_ce_o=1 until ram_data_i is valid; legal range 1..7.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- if_req_i  in  1  fetch request; held until if_ack_o
- if_addr_i  in  32  fetch byte address
- if_data_o  out  32  fetched word
- if_ack_o  out  1  one-cycle fetch completion
- flush_i  in  1  discard pending/in-flight fetch
- mem_req_i  in  1  data request; held until mem_ack_o
- mem_we_i  in  1  1 = store, 0 = load
- mem_sel_i  in  4  byte enables
- mem_addr_i  in  32  data byte address
- mem_data_i  in  32  store data
- mem_data_o  out  32  load data
- mem_ack_o  out  1  one-cycle data completion
- ram_ce_o  out  1  RAM enable
- ram_we_o  out  1  RAM write enable
- ram_sel_o  out  4  RAM byte enables
- ram_addr_o  out  32  RAM address
- ram_data_o  out  32  RAM write data
- ram_data_i  in  32  RAM read data
- stallreq_o  out  1  pipeline stall request to ctrl

Behaviour:
- Reset: asynchronous, takes effect immediately, including mid-access.
  - State goes to IDLE; counter = 0; fair pointer = IF.
  - All outputs are 0.
  - ram_ce_o drops in the same cycle rst rises.
- States: IDLE, BUSY_IF, BUSY_MEM, ACK.
- IDLE:
  - Evaluates requests each cycle.
  - Default priority: mem over if.
  - IF is eligible only when if_req_i=1 and flush_i=0.
  - On grant, latches addr, we, sel, data and the granted port (for IF: we=0, sel=4'b1111). Next state is BUSY_x; counter = RAM_LATENCY.
- BUSY_x:
  - ram_* outputs are driven from the latched registers; ram_ce_o=1.
  - Counter decrements each cycle.
  - In the cycle counter==1, ram_data_i is captured into if_data_o (IF) or mem_data_o (mem load). Next state is ACK.
- ACK:
  - ram_ce_o=0.
  - if_ack_o or mem_ack_o = 1 for exactly this cycle; next state is IDLE.
  - New grants are evaluated one cycle later (IDLE), so a requester's still-high req in its own ack cycle is never regranted.
- Timing: req-to-ack latency is RAM_LATENCY+2 cycles (IDLE grant, RAM_LATENCY busy cycles, ACK).
- Stores: mem_data_o is unchanged.
- Data outputs hold their value until the next capture. Acks are 0 outside ACK.
- ram_ce_o/we/sel/addr/data outputs are 0 in IDLE and ACK.
- stallreq_o = (if_req_i & ~if_ack_o) | (mem_req_i & ~mem_ack_o), combinational.
- flush_i:
  - Asserted in any cycle of BUSY_IF or ACK-of-IF sets a discard flag. The RAM access completes unchanged, but if_ack_o is suppressed and if_data_o is not updated.
  - The flag clears on return to IDLE.
  - flush_i never affects a mem transaction.
- Simultaneous if_req_i and mem_req_i in IDLE: mem wins (default). IF waits, stallreq_o=1.
- Requests dropped mid-transaction are protocol violations. The transaction still completes and is acked.
- Address alignment is not checked; addresses pass through unmodified.

Optional Feature:
- Macro: MEM_PORT_ARB_FAIR_EN.
- Defined:
  - A 1-bit last-grant register (reset = IF) records the most recent grant.
  - When both ports are eligible in IDLE, the port not granted last wins.
  - A single eligible port is always granted.
- Undefined: fixed mem-over-if priority; no last-grant register.

Test Plan:
- Single fetch, RAM_LATENCY=1, RAM word 0x3C010101 at address 0x0 -> ram_ce_o high 1 cycle with ram_addr_o=0x0, if_ack_o=1 on 3rd cycle after req, if_data_o=0x3C010101, stallreq_o=1 until ack.
- Store then load, RAM_LATENCY=2: mem_we_i=1, sel=4'b0011, addr 0x40, data 0xAABBCCDD over old 0x11223344 -> load of 0x40 returns 0x1122CCDD, each ack 4 cycles after req.
- Simultaneous if_req_i/mem_req_i held high -> mem acked first, IF granted in the IDLE cycle after mem ACK. With MEM_PORT_ARB_FAIR_EN and a second back-to-back mem request, IF wins the next tie.
- flush_i pulsed during BUSY_IF -> access completes (ram_ce_o pattern unchanged), no if_ack_o, if_data_o retains previous value. flush_i high in IDLE with only if_req_i -> no grant that cycle.
- rst asserted in middle of BUSY_MEM (RAM_LATENCY=3) -> ram_ce_o and all outputs 0 immediately, no mem_ack_o. After release, the held request is regranted and acked normally.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the openmips fetch/data ports, the shared RAM and mem_port_arbiter.
// slave: arbiter side; master: core-plus-RAM side.
interface mem_port_arbiter_if;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_data_o;
  logic        if_ack_o;
  logic        flush_i;
  logic        mem_req_i;
  logic        mem_we_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_data_i;
  logic [31:0] mem_data_o;
  logic        mem_ack_o;
  logic        ram_ce_o;
  logic        ram_we_o;
  logic [3:0]  ram_sel_o;
  logic [31:0] ram_addr_o;
  logic [31:0] ram_data_o;
  logic [31:0] ram_data_i;
  logic        stallreq_o;

  modport slave (
    input  if_req_i, if_addr_i, flush_i,
    input  mem_req_i, mem_we_i, mem_sel_i, mem_addr_i, mem_data_i,
    input  ram_data_i,
    output if_data_o, if_ack_o, mem_data_o, mem_ack_o,
    output ram_ce_o, ram_we_o, ram_sel_o, ram_addr_o, ram_data_o,
    output stallreq_o
  );

  modport master (
    output if_req_i, if_addr_i, flush_i,
    output mem_req_i, mem_we_i, mem_sel_i, mem_addr_i, mem_data_i,
    output ram_data_i,
    input  if_data_o, if_ack_o, mem_data_o, mem_ack_o,
    input  ram_ce_o, ram_we_o, ram_sel_o, ram_addr_o, ram_data_o,
    input  stallreq_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port RAM between the fetch and load/store ports.
// Optional MEM_PORT_ARB_FAIR_EN: ties go to the port not granted last (default: mem over if).
module mem_port_arbiter #(
  parameter int unsigned RAM_LATENCY = 1
) (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM, ACK} state_t;
  typedef enum logic {PORT_IF, PORT_MEM} port_t;

  localparam logic [2:0] LAT = 3'(RAM_LATENCY);

  state_t      state, state_nxt;
  port_t       port_q;
  logic [2:0]  cnt;
  logic        discard;
  logic        we_q;
  logic [3:0]  sel_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] if_data_q;
  logic [31:0] mem_data_q;

  logic if_ok;
  logic grant_if, grant_mem;
  logic busy, last_busy;

`ifdef MEM_PORT_ARB_FAIR_EN
  port_t last_grant;
`endif

  assign if_ok     = bus.if_req_i & ~bus.flush_i;
  assign busy      = (state == BUSY_IF) || (state == BUSY_MEM);
  assign last_busy = busy && (cnt == 3'd1);

  always_comb begin
    grant_if  = 1'b0;
    grant_mem = 1'b0;
    if (state == IDLE) begin
`ifdef MEM_PORT_ARB_FAIR_EN
      if (bus.mem_req_i && if_ok) begin
        grant_if  = (last_grant == PORT_MEM);
        grant_mem = (last_grant == PORT_IF);
      end else begin
        grant_mem = bus.mem_req_i;
        grant_if  = if_ok;
      end
`else
      grant_mem = bus.mem_req_i;
      grant_if  = if_ok & ~bus.mem_req_i;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_mem)     state_nxt = BUSY_MEM;
        else if (grant_if) state_nxt = BUSY_IF;
      end
      BUSY_IF, BUSY_MEM: if (cnt == 3'd1) state_nxt = ACK;
      ACK:               state_nxt = IDLE;
      default:           state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      port_q     <= PORT_IF;
      cnt        <= '0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_data_q  <= '0;
      mem_data_q <= '0;
      discard    <= 1'b0;
    end else begin
      if (grant_mem) begin
        port_q  <= PORT_MEM;
        we_q    <= bus.mem_we_i;
        sel_q   <= bus.mem_sel_i;
        addr_q  <= bus.mem_addr_i;
        wdata_q <= bus.mem_data_i;
        cnt     <= LAT;
      end else if (grant_if) begin
        port_q  <= PORT_IF;
        we_q    <= 1'b0;
        sel_q   <= '1;
        addr_q  <= bus.if_addr_i;
        wdata_q <= '0;
        cnt     <= LAT;
      end else if (busy) begin
        cnt <= cnt - 3'd1;
      end

      // a flush in the capture cycle itself must also keep the old fetch word
      if (last_busy && state == BUSY_IF && !discard && !bus.flush_i)
        if_data_q <= bus.ram_data_i;
      if (last_busy && state == BUSY_MEM && !we_q)
        mem_data_q <= bus.ram_data_i;

      if (state == IDLE)
        discard <= 1'b0;
      else if (bus.flush_i && port_q == PORT_IF && state != BUSY_MEM)
        discard <= 1'b1;
    end
  end

`ifdef MEM_PORT_ARB_FAIR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            last_grant <= PORT_IF;
    else if (grant_mem) last_grant <= PORT_MEM;
    else if (grant_if)  last_grant <= PORT_IF;
  end
`endif

  always_comb begin
    bus.ram_ce_o   = 1'b0;
    bus.ram_we_o   = 1'b0;
    bus.ram_sel_o  = '0;
    bus.ram_addr_o = '0;
    bus.ram_data_o = '0;
    bus.if_ack_o   = 1'b0;
    bus.mem_ack_o  = 1'b0;
    if (busy) begin
      bus.ram_ce_o   = 1'b1;
      bus.ram_we_o   = we_q;
      bus.ram_sel_o  = sel_q;
      bus.ram_addr_o = addr_q;
      bus.ram_data_o = wdata_q;
    end
    if (state == ACK) begin
      bus.if_ack_o  = (port_q == PORT_IF) && !discard && !bus.flush_i;
      bus.mem_ack_o = (port_q == PORT_MEM);
    end
  end

  assign bus.if_data_o  = if_data_q;
  assign bus.mem_data_o = mem_data_q;
  // gated by rst so every output reads 0 while reset is held
  assign bus.stallreq_o = ~rst & ((bus.if_req_i & ~bus.if_ack_o) |
                                  (bus.mem_req_i & ~bus.mem_ack_o));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a latency-accurate RAM model (RAM_LATENCY=3).
module tb_mem_port_arbiter;
  localparam int unsigned L = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.RAM_LATENCY(L)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    logic [7:0] b;
    b = 8'(i);
    if (i == 0)  return 32'h3C010101;
    if (i == 16) return 32'h11223344;
    return {8'h5A, b, ~b, b ^ 8'h3C};
  endfunction

  // RAM: read data valid only in the L-th consecutive cycle of ram_ce_o
  logic [31:0] ram [0:255];
  int ce_cnt;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
      ce_cnt <= 0;
    end else begin
      ce_cnt <= bus.ram_ce_o ? ce_cnt + 1 : 0;
      if (bus.ram_ce_o && bus.ram_we_o)
        for (int b = 0; b < 4; b++)
          if (bus.ram_sel_o[b]) ram[bus.ram_addr_o[9:2]][8*b +: 8] <= bus.ram_data_o[8*b +: 8];
    end
  end
  assign bus.ram_data_i = (bus.ram_ce_o && ce_cnt == int'(L) - 1) ?
                          ram[bus.ram_addr_o[9:2]] : 32'hDEADBEEF;

  typedef struct {
    bit          is_mem;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  always @(negedge clk) begin
    exp_t e;
    if (!rst && (bus.if_ack_o || bus.mem_ack_o)) begin
      if (sb.size() == 0) begin
        chk("spurious_ack", {30'b0, bus.if_ack_o, bus.mem_ack_o}, 32'h0);
      end else begin
        e = sb.pop_front();
        chk("ack_port", {30'b0, bus.if_ack_o, bus.mem_ack_o}, e.is_mem ? 32'h1 : 32'h2);
        chk(e.is_mem ? "mem_data" : "if_data", e.is_mem ? bus.mem_data_o : bus.if_data_o, e.data);
        chk("ack_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic wait_ack(input bit is_mem, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      seen = is_mem ? bus.mem_ack_o : bus.if_ack_o;
    end
  endtask

  // Uncontended transaction with cycle-by-cycle RAM-side and stall checks.
  task automatic solo(input bit is_mem, input bit we, input logic [3:0] sel,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_data, input bit flush_mid);
    int c;
    bit ce_exp;
    @(posedge clk); #1;
    c = cyc;
    if (is_mem) begin
      bus.mem_req_i = 1'b1; bus.mem_we_i = we; bus.mem_sel_i = sel;
      bus.mem_addr_i = addr; bus.mem_data_i = wdata;
    end else begin
      bus.if_req_i = 1'b1; bus.if_addr_i = addr;
    end
    if (is_mem || !flush_mid) sb.push_back('{is_mem, exp_data, c + int'(L) + 1});
    for (int k = 0; k <= int'(L) + 1; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      bus.flush_i = flush_mid && (k == 2);
      @(negedge clk);
      ce_exp = (k >= 1 && k <= int'(L));
      chk("ram_ce", 32'(bus.ram_ce_o), 32'(ce_exp));
      chk("ram_addr", bus.ram_addr_o, ce_exp ? addr : 32'h0);
      chk("ram_we", 32'(bus.ram_we_o), 32'(ce_exp && is_mem && we));
      chk("ram_sel", 32'(bus.ram_sel_o), ce_exp ? (is_mem ? 32'(sel) : 32'hF) : 32'h0);
      if (is_mem) chk("ram_wdata", bus.ram_data_o, ce_exp ? wdata : 32'h0);
      chk("stallreq", 32'(bus.stallreq_o), 32'((k <= int'(L)) || (flush_mid && !is_mem)));
    end
    @(posedge clk); #1;
    bus.if_req_i = 1'b0; bus.mem_req_i = 1'b0; bus.flush_i = 1'b0;
  endtask

  bit s_if, s_mem;
  int c;

  initial begin
    bus.if_req_i = 1'b0; bus.if_addr_i = '0; bus.flush_i = 1'b0;
    bus.mem_req_i = 1'b0; bus.mem_we_i = 1'b0; bus.mem_sel_i = '0;
    bus.mem_addr_i = '0; bus.mem_data_i = '0;
    #1 rst = 1'b1;
    #2;
    chk("rst_ram", {bus.ram_ce_o, bus.ram_we_o, bus.ram_sel_o, 26'b0}, 32'h0);
    chk("rst_ram_addr", bus.ram_addr_o | bus.ram_data_o, 32'h0);
    chk("rst_acks_stall", {29'b0, bus.if_ack_o, bus.mem_ack_o, bus.stallreq_o}, 32'h0);
    chk("rst_data", bus.if_data_o | bus.mem_data_o, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // single fetch, store, load of the stored word, flushed fetch
    solo(1'b0, 1'b0, 4'hF, 32'h0, 32'h0, 32'h3C010101, 1'b0);
    solo(1'b1, 1'b1, 4'b0011, 32'h40, 32'hAABBCCDD, 32'h0, 1'b0);
    solo(1'b1, 1'b0, 4'hF, 32'h40, 32'h0, 32'h1122CCDD, 1'b0);
    solo(1'b0, 1'b0, 4'hF, 32'h8, 32'h0, 32'h0, 1'b1);
    chk("if_data_kept", bus.if_data_o, 32'h3C010101);

    // flush held in IDLE blocks the grant for that cycle
    @(posedge clk); #1;
    c = cyc;
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'hC; bus.flush_i = 1'b1;
    sb.push_back('{1'b0, init_word(3), c + int'(L) + 2});
    @(negedge clk);
    chk("idle_flush_stall", 32'(bus.stallreq_o), 32'h1);
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    @(negedge clk);
    chk("idle_flush_nogrant", 32'(bus.ram_ce_o), 32'h0);
    wait_ack(1'b0, s_if);
    chk("idle_flush_ack_seen", 32'(s_if), 32'h1);
    @(posedge clk); #1;
    bus.if_req_i = 1'b0;

    // simultaneous requests: mem first, IF right after
    @(posedge clk); #1;
    c = cyc;
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h4;
    bus.mem_req_i = 1'b1; bus.mem_we_i = 1'b0; bus.mem_sel_i = 4'hF; bus.mem_addr_i = 32'h48;
    sb.push_back('{1'b1, init_word(18), c + int'(L) + 1});
    sb.push_back('{1'b0, init_word(1), c + 2 * int'(L) + 3});
    @(negedge clk);
    chk("tie_stall", 32'(bus.stallreq_o), 32'h1);
    fork
      begin
        wait_ack(1'b1, s_mem);
        chk("tie_mem_seen", 32'(s_mem), 32'h1);
        @(posedge clk); #1;
        bus.mem_req_i = 1'b0;
      end
      begin
        wait_ack(1'b0, s_if);
        chk("tie_if_seen", 32'(s_if), 32'h1);
        @(posedge clk); #1;
        bus.if_req_i = 1'b0;
      end
    join

    // tie with a back-to-back second mem request
    @(posedge clk); #1;
    c = cyc;
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'hC;
    bus.mem_req_i = 1'b1; bus.mem_addr_i = 32'h4C;
    sb.push_back('{1'b1, init_word(19), c + int'(L) + 1});
`ifdef MEM_PORT_ARB_FAIR_EN
    sb.push_back('{1'b0, init_word(3), c + 2 * int'(L) + 3});
    sb.push_back('{1'b1, init_word(20), c + 3 * int'(L) + 5});
`else
    sb.push_back('{1'b1, init_word(20), c + 2 * int'(L) + 3});
    sb.push_back('{1'b0, init_word(3), c + 3 * int'(L) + 5});
`endif
    fork
      begin
        wait_ack(1'b1, s_mem);
        chk("b2b_mem1_seen", 32'(s_mem), 32'h1);
        @(posedge clk); #1;
        bus.mem_addr_i = 32'h50;
        wait_ack(1'b1, s_mem);
        chk("b2b_mem2_seen", 32'(s_mem), 32'h1);
        @(posedge clk); #1;
        bus.mem_req_i = 1'b0;
      end
      begin
        wait_ack(1'b0, s_if);
        chk("b2b_if_seen", 32'(s_if), 32'h1);
        @(posedge clk); #1;
        bus.if_req_i = 1'b0;
      end
    join

    // reset in the middle of a load, request held through reset
    @(posedge clk); #1;
    bus.mem_req_i = 1'b1; bus.mem_we_i = 1'b0; bus.mem_addr_i = 32'h44;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst_ce", 32'(bus.ram_ce_o), 32'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_ram", {bus.ram_ce_o, bus.ram_we_o, bus.ram_sel_o, 26'b0}, 32'h0);
    chk("mid_rst_ram_addr", bus.ram_addr_o | bus.ram_data_o, 32'h0);
    chk("mid_rst_acks_stall", {29'b0, bus.if_ack_o, bus.mem_ack_o, bus.stallreq_o}, 32'h0);
    chk("mid_rst_data", bus.if_data_o | bus.mem_data_o, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    c = cyc;
    sb.push_back('{1'b1, init_word(17), c + int'(L) + 1});
    wait_ack(1'b1, s_mem);
    chk("post_rst_ack_seen", 32'(s_mem), 32'h1);
    @(posedge clk); #1;
    bus.mem_req_i = 1'b0;

    repeat (4) @(posedge clk);
    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
